bin2bcd_seq: RTL and testbench
==============================

BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

Interface
REQ-001 The block SHALL have parameter BIN_W, default 16: width of the binary input and number of conversion iterations.
REQ-002 The block SHALL have parameter DIGITS, default 4: number of BCD digits produced; the BCD output width is 4*DIGITS.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port start, input, 1 bit: conversion request, sampled only in IDLE.
REQ-006 The block SHALL have port bin_in, input, BIN_W bits: unsigned binary value, sampled on the accepted start edge.
REQ-007 The block SHALL have port busy, output, 1 bit: high while in CONVERT.
REQ-008 The block SHALL have port done, output, 1 bit: single-cycle pulse when bcd_out is updated.
REQ-009 The block SHALL have port bcd_out, output, 4*DIGITS bits: packed BCD with ones at [3:0], tens at [7:4], hundreds at [11:8], thousands at [15:12]; it feeds the 16-bit input of the team's 7-segment decoder stage directly.
REQ-010 The block SHALL have port overflow, output, 1 bit: high when the last accepted bin_in exceeded 10^DIGITS-1.

Function
REQ-011 The FSM SHALL have two states, IDLE and CONVERT, and SHALL reset to IDLE.
REQ-012 In IDLE with start=1 at edge k, the block SHALL capture sat = min(bin_in, 10^DIGITS-1) into a BIN_W-bit shift register, clear a 4*DIGITS-bit scratch register, load iteration counter = 0, and enter CONVERT.
REQ-013 On the same edge k, the block SHALL register overflow = (bin_in > 10^DIGITS-1); overflow SHALL then hold until the next accepted start.
REQ-014 Each CONVERT edge SHALL perform one shift-add-3 iteration: every scratch digit >= 5 gets +3 (4-bit result, no carry between digits); then {scratch, shift} shifts left by one bit and the counter increments.
REQ-015 Conversion SHALL be exactly BIN_W iterations, on edges k+1 .. k+BIN_W.
REQ-016 At edge k+BIN_W, bcd_out SHALL load the final scratch value, done SHALL go to 1 for exactly one cycle, and the FSM SHALL return to IDLE.
REQ-017 Latency SHALL be BIN_W cycles from the accepted start edge to the done edge (16 with defaults); busy=1 during cycles after edges k .. k+BIN_W-1.
REQ-018 Start while in CONVERT SHALL be ignored, with no queuing and no effect on the current conversion.
REQ-019 Start asserted during the done cycle SHALL be accepted, since the FSM is already in IDLE; back-to-back throughput is one result per BIN_W+1 cycles.
REQ-020 bcd_out SHALL hold its last value between done pulses; it SHALL never show intermediate scratch values.
REQ-021 Held-high start SHALL restart a conversion on every IDLE cycle.
REQ-022 Every bcd_out digit SHALL be in the range 0..9 for any bin_in, because of saturation.

Reset
REQ-023 rst_n=0 SHALL immediately force state=IDLE, busy=0, done=0, overflow=0, bcd_out=0 (decoder shows "0000"), and clear the shift, scratch and counter registers, independent of clk.
REQ-024 Reset asserted mid-conversion SHALL abort it; no done pulse follows and bcd_out stays 0 after release.
REQ-025 After rst_n deasserts, the first rising edge SHALL be able to accept start.

Verification
REQ-026 Reset, then start with bin_in=0 -> done 16 cycles later, bcd_out=16'h0000, overflow=0.
REQ-027 bin_in=1234 -> busy high 16 cycles, done one cycle, bcd_out=16'h1234, overflow=0.
REQ-028 bin_in=9999, then start in the done cycle with bin_in=10000 -> bcd_out=16'h9999 overflow=0, then bcd_out=16'h9999 overflow=1.
REQ-029 bin_in=65535 -> bcd_out=16'h9999, overflow=1; next start with bin_in=42 -> bcd_out=16'h0042, overflow=0.
REQ-030 Start bin_in=5678, pulse start with bin_in=1111 at cycle 5 of CONVERT -> exactly one done, bcd_out=16'h5678.
REQ-031 Start bin_in=4321, assert rst_n=0 at cycle 8 -> busy=0, done=0, bcd_out=0 immediately, and no done afterwards.

Source files
------------

// File: rtl/bin2bcd_seq.sv
`default_nettype none
// ============================================================================
//  Module      : bin2bcd_seq
//  Description : Sequential binary-to-BCD converter (shift-add-3 / double
//                dabble), one iteration per clock. Inputs above the largest
//                representable decimal value saturate to all-nines and
//                raise overflow.
//  Ports       : clk      - clock, rising edge
//                rst_n    - asynchronous active-low reset
//                start    - conversion request, honoured only when idle
//                bin_in   - unsigned binary value, captured on accepted start
//                busy     - high while converting
//                done     - one-cycle pulse when bcd_out updates
//                bcd_out  - packed BCD result, ones digit in [3:0]
//                overflow - last accepted bin_in exceeded 10^DIGITS-1
//  Revision    : 1.0 - initial release
// ============================================================================
module bin2bcd_seq #(
    parameter int BIN_W  = 16,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  overflow
);

    localparam int c_bcd_w = 4 * DIGITS;
    localparam int c_cnt_w = $clog2(BIN_W + 1);

    function automatic logic [63:0] pow10_minus1(input int n);
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < n; i++) begin
            p = p * 64'd10;
        end
        return p - 64'd1;
    endfunction

    localparam logic [63:0]        c_max_dec = pow10_minus1(DIGITS);
    localparam logic [c_cnt_w-1:0] c_last    = c_cnt_w'(BIN_W - 1);

    typedef enum logic [0:0] {
        S_IDLE    = 1'b0,
        S_CONVERT = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_next_state;
    logic                 w_load;
    logic                 w_step;
    logic                 w_last;

    logic [BIN_W-1:0]     r_shift;
    logic [c_bcd_w-1:0]   r_scratch;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [c_bcd_w-1:0]   r_bcd;
    logic                 r_done;
    logic                 r_overflow;

    logic                 w_over;
    logic [BIN_W-1:0]     w_sat;
    logic [c_bcd_w-1:0]   w_adj;
    logic [c_bcd_w-1:0]   w_scratch_nxt;

    // If 10^DIGITS-1 does not fit in BIN_W bits, w_over can never be true,
    // so the truncated slice of c_max_dec below is never selected.
    assign w_over = (64'(bin_in) > c_max_dec);
    assign w_sat  = w_over ? c_max_dec[BIN_W-1:0] : bin_in;

    // Per-digit add-3 correction; each digit is independent (no carries).
    generate
        for (genvar d = 0; d < DIGITS; d++) begin : g_digit
            always_comb begin
                w_adj[4*d +: 4] = r_scratch[4*d +: 4];
                if (r_scratch[4*d +: 4] >= 4'd5) begin
                    w_adj[4*d +: 4] = r_scratch[4*d +: 4] + 4'd3;
                end
            end
        end
    endgenerate

    // Shift the corrected scratch and the binary register left as one word.
    assign w_scratch_nxt = {w_adj[c_bcd_w-2:0], r_shift[BIN_W-1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_step       = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_load       = 1'b1;
                    w_next_state = S_CONVERT;
                end
            end
            S_CONVERT: begin
                w_step = 1'b1;
                if (r_cnt == c_last) begin
                    w_last       = 1'b1;
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift    <= '0;
            r_scratch  <= '0;
            r_cnt      <= '0;
            r_bcd      <= '0;
            r_done     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_load) begin
                r_shift    <= w_sat;
                r_scratch  <= '0;
                r_cnt      <= '0;
                r_overflow <= w_over;
            end else if (w_step) begin
                r_scratch <= w_scratch_nxt;
                r_shift   <= r_shift << 1;
                r_cnt     <= r_cnt + c_cnt_w'(1);
                // Only the completed value is ever exposed on bcd_out.
                if (w_last) begin
                    r_bcd  <= w_scratch_nxt;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign busy     = (r_state == S_CONVERT);
    assign done     = r_done;
    assign bcd_out  = r_bcd;
    assign overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_bin2bcd_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bin2bcd_seq
//  Description : Self-checking bench for bin2bcd_seq (default parameters).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bin2bcd_seq;

    localparam int BIN_W = 16;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] bin_in;
    logic        busy;
    logic        done;
    logic [15:0] bcd_out;
    logic        overflow;

    int tests_run;
    int tests_failed;
    logic [15:0] exp_hold;

    typedef struct {
        logic [15:0] bin;
        logic [15:0] bcd;
        logic        ovf;
    } vec_t;

    vec_t vecs [12];

    bin2bcd_seq #(.BIN_W(16), .DIGITS(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .bin_in   (bin_in),
        .busy     (busy),
        .done     (done),
        .bcd_out  (bcd_out),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Called away from a clock edge with the DUT idle. Requests a conversion,
    // then follows it edge by edge. If pulse_at > 0, a start with bin_in=1111
    // is driven for one cycle after that many CONVERT edges.
    task automatic run_conv(input logic [15:0] bin, input logic [15:0] exp_bcd,
                            input logic exp_ovf, input int pulse_at);
        start  = 1'b1;
        bin_in = bin;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("busy_after_start", {31'd0, busy}, 32'd1);
        for (int i = 1; i <= BIN_W; i++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            if (i < BIN_W) begin
                check("busy_mid", {31'd0, busy}, 32'd1);
                check("done_mid", {31'd0, done}, 32'd0);
                check("bcd_hold", {16'd0, bcd_out}, {16'd0, exp_hold});
                if (i == pulse_at) begin
                    start  = 1'b1;
                    bin_in = 16'd1111;
                end
            end else begin
                check("done_pulse", {31'd0, done}, 32'd1);
                check("busy_end", {31'd0, busy}, 32'd0);
                check("bcd_result", {16'd0, bcd_out}, {16'd0, exp_bcd});
                check("overflow", {31'd0, overflow}, {31'd0, exp_ovf});
            end
        end
        exp_hold = exp_bcd;
    endtask

    task automatic idle_cycles(input int n, input logic [15:0] exp_bcd);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            check("idle_no_done", {31'd0, done}, 32'd0);
            check("idle_busy", {31'd0, busy}, 32'd0);
            check("idle_bcd", {16'd0, bcd_out}, {16'd0, exp_bcd});
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        exp_hold     = 16'h0000;
        start        = 1'b0;
        bin_in       = 16'd0;
        rst_n        = 1'b0;

        vecs[0]  = '{16'd0,     16'h0000, 1'b0};
        vecs[1]  = '{16'd1234,  16'h1234, 1'b0};
        vecs[2]  = '{16'd9999,  16'h9999, 1'b0};
        vecs[3]  = '{16'd10000, 16'h9999, 1'b1};
        vecs[4]  = '{16'd65535, 16'h9999, 1'b1};
        vecs[5]  = '{16'd42,    16'h0042, 1'b0};
        vecs[6]  = '{16'd9,     16'h0009, 1'b0};
        vecs[7]  = '{16'd10,    16'h0010, 1'b0};
        vecs[8]  = '{16'd255,   16'h0255, 1'b0};
        vecs[9]  = '{16'd8000,  16'h8000, 1'b0};
        vecs[10] = '{16'd9990,  16'h9990, 1'b0};
        vecs[11] = '{16'd1,     16'h0001, 1'b0};

        // Reset state, before any clock edge.
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_bcd", {16'd0, bcd_out}, 32'd0);
        check("rst_ovf", {31'd0, overflow}, 32'd0);
        #20;
        rst_n = 1'b1;
        idle_cycles(2, 16'h0000);

        // Table: consecutive entries start in the previous done cycle.
        for (int v = 0; v < 12; v++) begin
            run_conv(vecs[v].bin, vecs[v].bcd, vecs[v].ovf, 0);
        end
        idle_cycles(2, exp_hold);
        check("ovf_hold_idle", {31'd0, overflow}, 32'd0);

        // Start during CONVERT is ignored: one done only, result of 5678.
        run_conv(16'd5678, 16'h5678, 1'b0, 5);
        idle_cycles(20, 16'h5678);

        // Overflow then a normal value.
        run_conv(16'd65535, 16'h9999, 1'b1, 0);
        idle_cycles(3, 16'h9999);
        check("ovf_hold", {31'd0, overflow}, 32'd1);
        run_conv(16'd42, 16'h0042, 1'b0, 0);

        // Reset mid-conversion aborts with no later done.
        start  = 1'b1;
        bin_in = 16'd4321;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
        end
        #3;
        rst_n = 1'b0;
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_bcd", {16'd0, bcd_out}, 32'd0);
        check("abort_ovf", {31'd0, overflow}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_hold = 16'h0000;
        idle_cycles(20, 16'h0000);

        // First edge after reset release accepts start.
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        run_conv(16'd7, 16'h0007, 1'b0, 0);

        // Held-high start restarts on every IDLE cycle.
        start  = 1'b1;
        bin_in = 16'd300;
        @(posedge clk);
        for (int i = 1; i <= BIN_W; i++) begin
            @(posedge clk);
        end
        #1;
        check("held_done", {31'd0, done}, 32'd1);
        check("held_bcd", {16'd0, bcd_out}, 32'h0300);
        @(posedge clk);
        #1;
        check("held_restart_busy", {31'd0, busy}, 32'd1);
        start = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
